// File: rtl/eeprom_writer_if.sv
// eeprom_writer_if: CPU request/status signals plus the four Microwire pins
// of the AT93C86A, bundled for eeprom_writer.
// master = CPU/EEPROM side, slave = the write controller itself.
interface eeprom_writer_if;
  logic [10:0] address;
  logic [7:0]  data_in;
  logic        strobe;
  logic        eeprom_cs;
  logic        eeprom_clk;
  logic        eeprom_di;
  logic        eeprom_do;
  logic        ready;
  logic        error;

  modport master (
    output address, data_in, strobe, eeprom_do,
    input  eeprom_cs, eeprom_clk, eeprom_di, ready, error
  );

  modport slave (
    input  address, data_in, strobe, eeprom_do,
    output eeprom_cs, eeprom_clk, eeprom_di, ready, error
  );
endinterface

// File: rtl/eeprom_writer.sv
// eeprom_writer: single-byte write controller for an AT93C86A (x8, 2048 x 8)
// Microwire EEPROM. A strobe runs EWEN, WRITE, a ready/busy poll on DO and a
// CS release, then reports done on ready and a write-cycle timeout on error.
// Optional build macro EEPROM_AUTO_EWDS_EN: when defined, an EWDS command is
// shifted after the poll so the part is left write-protected after each write.
module eeprom_writer #(
  parameter int HALF_PERIOD    = 8,
  parameter int CS_GAP         = 4,
  parameter int STATUS_DELAY   = 4,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic           raw_clk,
  input  logic           reset_n,
  eeprom_writer_if.slave bus
);

  localparam int DLY_MAX_HG = (HALF_PERIOD > CS_GAP) ? HALF_PERIOD : CS_GAP;
  localparam int DLY_MAX    = (DLY_MAX_HG > STATUS_DELAY) ? DLY_MAX_HG : STATUS_DELAY;
  localparam int DLY_W      = $clog2(DLY_MAX + 1);

  localparam logic [DLY_W-1:0] HALF_LAST   = DLY_W'(HALF_PERIOD - 1);
  localparam logic [DLY_W-1:0] GAP_LAST    = DLY_W'(CS_GAP - 1);
  localparam logic [DLY_W-1:0] STATUS_WAIT = DLY_W'(STATUS_DELAY);
  localparam logic [16:0]      TMO_LAST    = 17'(TIMEOUT_CYCLES - 1);

  localparam logic [13:0] EWEN_CMD = 14'b10011000000000;
  localparam logic [13:0] EWDS_CMD = 14'b10000000000000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_EWEN,
    ST_GAP1,
    ST_WRITE,
    ST_GAP2,
    ST_POLL,
    ST_GAP3,
    ST_EWDS,
    ST_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic             cs_q, cs_d;
  logic             clk_q, clk_d;
  logic             di_q, di_d;
  logic             ready_q, ready_d;
  logic             error_q, error_d;
  logic [10:0]      addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [21:0]      sr_q, sr_d;
  logic [4:0]       bit_q, bit_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [16:0]      tmo_q, tmo_d;
  logic [4:0]       shift_last;
  logic             poll_done;

  // Next-state logic: sequences commands, bit cells, CS gaps and the busy poll.
  always_comb begin
    state_d    = state_q;
    cs_d       = cs_q;
    clk_d      = clk_q;
    di_d       = di_q;
    ready_d    = ready_q;
    error_d    = error_q;
    addr_d     = addr_q;
    data_d     = data_q;
    sr_d       = sr_q;
    bit_d      = bit_q;
    dly_d      = dly_q;
    tmo_d      = tmo_q;
    poll_done  = 1'b0;
    shift_last = (state_q == ST_WRITE) ? 5'd21 : 5'd13;

    case (state_q)
      ST_IDLE: begin
        cs_d    = 1'b0;
        clk_d   = 1'b0;
        di_d    = 1'b0;
        ready_d = 1'b1;
        bit_d   = '0;
        dly_d   = '0;
        if (bus.strobe) begin
          addr_d  = bus.address;
          data_d  = bus.data_in;
          error_d = 1'b0;
          ready_d = 1'b0;
          cs_d    = 1'b1;
          sr_d    = {EWEN_CMD, 8'h00};
          // every Microwire command opens with its start bit
          di_d    = 1'b1;
          state_d = ST_EWEN;
        end
      end

      ST_EWEN, ST_WRITE, ST_EWDS: begin
        if (dly_q == HALF_LAST) begin
          dly_d = '0;
          if (!clk_q) begin
            clk_d = 1'b1;
          end else begin
            clk_d = 1'b0;
            if (bit_q == shift_last) begin
              cs_d  = 1'b0;
              di_d  = 1'b0;
              bit_d = '0;
              if (state_q == ST_EWEN) begin
                state_d = ST_GAP1;
              end else if (state_q == ST_WRITE) begin
                state_d = ST_GAP2;
              end else begin
                state_d = ST_FINISH;
              end
            end else begin
              sr_d  = {sr_q[20:0], sr_q[21]};
              di_d  = sr_q[20];
              bit_d = bit_q + 5'd1;
            end
          end
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end

      ST_GAP1, ST_GAP2, ST_GAP3: begin
        if (dly_q == GAP_LAST) begin
          dly_d = '0;
          cs_d  = 1'b1;
          if (state_q == ST_GAP1) begin
            sr_d    = {3'b101, addr_q, data_q};
            di_d    = 1'b1;
            state_d = ST_WRITE;
          end else if (state_q == ST_GAP2) begin
            di_d    = 1'b0;
            tmo_d   = '0;
            state_d = ST_POLL;
          end else begin
            sr_d    = {EWDS_CMD, 8'h00};
            di_d    = 1'b1;
            state_d = ST_EWDS;
          end
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end

      ST_POLL: begin
        tmo_d = tmo_q + 17'd1;
        if (dly_q != STATUS_WAIT) begin
          dly_d = dly_q + 1'b1;
        end else if (bus.eeprom_do) begin
          poll_done = 1'b1;
        end
        if (!poll_done && (tmo_q == TMO_LAST)) begin
          error_d   = 1'b1;
          poll_done = 1'b1;
        end
        if (poll_done) begin
          cs_d  = 1'b0;
          dly_d = '0;
`ifdef EEPROM_AUTO_EWDS_EN
          state_d = ST_GAP3;
`else
          state_d = ST_FINISH;
`endif
        end
      end

      ST_FINISH: begin
        cs_d    = 1'b0;
        clk_d   = 1'b0;
        di_d    = 1'b0;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered pin outputs; a low reset_n abandons any command.
  always_ff @(posedge raw_clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cs_q    <= 1'b0;
      clk_q   <= 1'b0;
      di_q    <= 1'b0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sr_q    <= '0;
      bit_q   <= '0;
      dly_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      clk_q   <= clk_d;
      di_q    <= di_d;
      ready_q <= ready_d;
      error_q <= error_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      dly_q   <= dly_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.eeprom_cs  = cs_q;
  assign bus.eeprom_clk = clk_q;
  assign bus.eeprom_di  = di_q;
  assign bus.ready      = ready_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_eeprom_writer.sv
// tb_eeprom_writer: self-checking bench for eeprom_writer with a Microwire
// EEPROM model that captures shifted frames, measures bit-cell and CS-gap
// timing, and answers the busy poll on DO. The poll limit is shortened so
// timeout cases stay quick.
module tb_eeprom_writer;

  localparam int HALF_PERIOD  = 8;
  localparam int CS_GAP       = 4;
  localparam int STATUS_DELAY = 4;
  localparam int TB_TIMEOUT   = 3000;
  localparam logic [31:0] EWEN_FRAME = 32'h0000_2600;
  localparam logic [31:0] EWDS_FRAME = 32'h0000_2000;

  typedef struct {
    int          n;
    logic [31:0] v;
  } frame_t;

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
    int          busy;
    bit          pulse;
    bit          exp_err;
  } vec_t;

  logic raw_clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  eeprom_writer_if bus();

  eeprom_writer #(
    .HALF_PERIOD   (HALF_PERIOD),
    .CS_GAP        (CS_GAP),
    .STATUS_DELAY  (STATUS_DELAY),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .raw_clk(raw_clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 raw_clk = ~raw_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int modelPollLen(input int b);
    int first_ok;
    first_ok = (b > STATUS_DELAY) ? b : STATUS_DELAY;
    return (first_ok >= TB_TIMEOUT) ? TB_TIMEOUT : first_ok + 1;
  endfunction

  function automatic bit modelTimeout(input int b);
    int first_ok;
    first_ok = (b > STATUS_DELAY) ? b : STATUS_DELAY;
    return first_ok >= TB_TIMEOUT;
  endfunction

  function automatic int modelLatency(input int b);
    int lat;
    lat = 36 * 2 * HALF_PERIOD + 2 * CS_GAP + modelPollLen(b) + 1;
`ifdef EEPROM_AUTO_EWDS_EN
    lat = lat + CS_GAP + 14 * 2 * HALF_PERIOD;
`endif
    return lat;
  endfunction

  // ---------------- EEPROM model / pin monitor ----------------
  frame_t      frames[$];
  int          busy_len   = 0;
  bit          abort_flag = 1'b0;
  logic        prev_cs = 1'b0, prev_clk = 1'b0, prev_di = 1'b0;
  int          phase_cnt = 0, low_cnt = 0, cur_n = 0, poll_cnt = 0;
  logic [31:0] cur_v = '0;
  bit          armed = 1'b0, polling = 1'b0;

  // Samples the pins on the falling raw_clk edge, collects frames and drives DO.
  always @(negedge raw_clk) begin
    logic cs, sclk, di;
    frame_t f;
    cs   = bus.eeprom_cs;
    sclk = bus.eeprom_clk;
    di   = bus.eeprom_di;
    if (cs === 1'b1 && prev_cs !== 1'b1) begin
      if (low_cnt > 0) checkOutput("cs_gap", low_cnt, CS_GAP);
      cur_n     = 0;
      cur_v     = '0;
      phase_cnt = 1;
      if (armed) begin
        polling  = 1'b1;
        poll_cnt = 0;
        armed    = 1'b0;
      end
    end else if (cs === 1'b1) begin
      if (sclk !== prev_clk) begin
        checkOutput("clk_phase", phase_cnt, HALF_PERIOD);
        phase_cnt = 1;
        if (sclk === 1'b1) begin
          checkOutput("di_stable", di, prev_di);
          cur_v = {cur_v[30:0], di};
          cur_n++;
        end
      end else begin
        phase_cnt++;
      end
    end else if (prev_cs === 1'b1) begin
      if (cur_n > 0 && !abort_flag) checkOutput("clk_phase_last", phase_cnt, HALF_PERIOD);
      f.n = cur_n;
      f.v = cur_v;
      frames.push_back(f);
      if (cur_n == 22) armed = 1'b1;
      polling = 1'b0;
    end
    if (cs === 1'b0 && bus.ready === 1'b0) low_cnt++;
    else low_cnt = 0;
    bus.eeprom_do = polling ? (poll_cnt >= busy_len) : 1'b1;
    if (polling) poll_cnt++;
    prev_cs  = cs;
    prev_clk = sclk;
    prev_di  = di;
  end

  // ---------------- stimulus helpers ----------------
  task automatic doReset();
    @(negedge raw_clk);
    reset_n = 1'b0;
    repeat (3) @(posedge raw_clk);
    @(negedge raw_clk);
    reset_n = 1'b1;
  endtask

  task automatic waitReady(input int limit, output int lat, output bit done);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < limit) begin
      @(posedge raw_clk);
      lat++;
      #1;
      if (bus.ready === 1'b1) done = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic [10:0] a, input logic [7:0] d, input bit pulse,
                               input int limit, output int lat, output bit done);
    @(negedge raw_clk);
    bus.address = a;
    bus.data_in = d;
    bus.strobe  = 1'b1;
    @(posedge raw_clk);
    #1;
    bus.strobe  = 1'b0;
    bus.address = 11'($urandom);
    bus.data_in = 8'($urandom);
    checkOutput("cs_after_strobe", bus.eeprom_cs, 1'b1);
    checkOutput("ready_after_strobe", bus.ready, 1'b0);
    checkOutput("error_cleared_on_accept", bus.error, 1'b0);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < limit) begin
      @(posedge raw_clk);
      lat++;
      #1;
      if (pulse && lat == 400) begin
        bus.strobe  = 1'b1;
        bus.address = ~a;
        bus.data_in = ~d;
      end
      if (pulse && lat == 403) bus.strobe = 1'b0;
      if (bus.ready === 1'b1) done = 1'b1;
    end
    bus.strobe = 1'b0;
  endtask

  task automatic runWrite(input string tag, input logic [10:0] a, input logic [7:0] d,
                          input int b, input bit pulse, input bit exp_err);
    int     lat;
    bit     done;
    frame_t exp_q[$];
    frame_t f;
    int     nf;
    busy_len = b;
    frames.delete();
    applyStimulus(a, d, pulse, modelLatency(b) + 100, lat, done);
    if (!done) begin
      checkOutput({tag, " ready_bound"}, 32'd0, 32'd1);
      abort_flag = 1'b1;
      doReset();
      repeat (2) @(negedge raw_clk);
      abort_flag = 1'b0;
      return;
    end
    checkOutput({tag, " latency"}, lat, modelLatency(b));
    checkOutput({tag, " error"}, bus.error, exp_err);
    checkOutput({tag, " cs_end"}, bus.eeprom_cs, 1'b0);
    repeat (3) @(posedge raw_clk);
    #1;
    checkOutput({tag, " stays_idle"}, {bus.ready, bus.eeprom_cs}, 2'b10);
    f.n = 14; f.v = EWEN_FRAME;                      exp_q.push_back(f);
    f.n = 22; f.v = {10'd0, 3'b101, a, d};           exp_q.push_back(f);
    f.n = 0;  f.v = '0;                              exp_q.push_back(f);
`ifdef EEPROM_AUTO_EWDS_EN
    f.n = 14; f.v = EWDS_FRAME;                      exp_q.push_back(f);
`endif
    checkOutput({tag, " frame_count"}, frames.size(), exp_q.size());
    nf = (frames.size() < exp_q.size()) ? frames.size() : exp_q.size();
    for (int i = 0; i < nf; i++) begin
      checkOutput({tag, " frame_bits"}, frames[i].n, exp_q[i].n);
      checkOutput({tag, " frame_value"}, frames[i].v, exp_q[i].v);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : main
    vec_t vecs[8];
    int   lat;
    bit   done;
    int   b;
    logic [10:0] ra;
    logic [7:0]  rd;

    vecs[0] = '{11'h5A3, 8'hC7, 500,            1'b0, 1'b0};
    vecs[1] = '{11'h000, 8'h00, 0,              1'b0, 1'b0};
    vecs[2] = '{11'h7FF, 8'hFF, STATUS_DELAY,   1'b0, 1'b0};
    vecs[3] = '{11'h2AA, 8'h55, STATUS_DELAY+1, 1'b0, 1'b0};
    vecs[4] = '{11'h155, 8'hAA, 300,            1'b1, 1'b0};
    vecs[5] = '{11'h400, 8'h81, TB_TIMEOUT-1,   1'b0, 1'b0};
    vecs[6] = '{11'h0F0, 8'h3C, TB_TIMEOUT,     1'b0, 1'b1};
    vecs[7] = '{11'h7FE, 8'h01, 1 << 30,        1'b0, 1'b1};

    reset_n     = 1'b0;
    bus.strobe  = 1'b0;
    bus.address = '0;
    bus.data_in = '0;
    repeat (3) @(posedge raw_clk);
    #1;
    checkOutput("reset_ready", bus.ready, 1'b1);
    checkOutput("reset_error", bus.error, 1'b0);
    checkOutput("reset_cs", bus.eeprom_cs, 1'b0);
    checkOutput("reset_clk", bus.eeprom_clk, 1'b0);
    checkOutput("reset_di", bus.eeprom_di, 1'b0);
    @(negedge raw_clk);
    reset_n = 1'b1;
    repeat (2) @(negedge raw_clk);

    for (int i = 0; i < 8; i++) begin
      runWrite($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].busy,
               vecs[i].pulse, vecs[i].exp_err);
    end

    // error from the last timed-out write must persist while idle
    repeat (20) @(posedge raw_clk);
    #1;
    checkOutput("error_persist", bus.error, 1'b1);
    checkOutput("error_persist_ready", bus.ready, 1'b1);

    // randomized writes against the reference model
    for (int i = 0; i < 6; i++) begin
      ra = 11'($urandom_range(0, 2047));
      rd = 8'($urandom_range(0, 255));
      b  = $urandom_range(0, 3200);
      runWrite($sformatf("rand%0d", i), ra, rd, b, 1'b0, modelTimeout(b));
    end

    // reset in the middle of the WRITE command
    busy_len = 500;
    frames.delete();
    @(negedge raw_clk);
    bus.address = 11'h3C3;
    bus.data_in = 8'h5A;
    bus.strobe  = 1'b1;
    @(posedge raw_clk);
    #1;
    bus.strobe = 1'b0;
    repeat (300) @(posedge raw_clk);
    abort_flag = 1'b1;
    @(negedge raw_clk);
    reset_n = 1'b0;
    @(posedge raw_clk);
    #1;
    checkOutput("abort_cs", bus.eeprom_cs, 1'b0);
    checkOutput("abort_ready", bus.ready, 1'b1);
    checkOutput("abort_clk", bus.eeprom_clk, 1'b0);
    @(negedge raw_clk);
    reset_n = 1'b1;
    repeat (3) @(negedge raw_clk);
    abort_flag = 1'b0;
    frames.delete();

    // strobe held high restarts on the first ready idle cycle
    busy_len = 10;
    @(negedge raw_clk);
    bus.address = 11'h111;
    bus.data_in = 8'h22;
    bus.strobe  = 1'b1;
    @(posedge raw_clk);
    #1;
    checkOutput("held_first_cs", bus.eeprom_cs, 1'b1);
    waitReady(modelLatency(10) + 100, lat, done);
    checkOutput("held_first_done", done, 1'b1);
    checkOutput("held_first_latency", lat, modelLatency(10));
    @(posedge raw_clk);
    #1;
    checkOutput("held_restart_cs", bus.eeprom_cs, 1'b1);
    checkOutput("held_restart_ready", bus.ready, 1'b0);
    bus.strobe = 1'b0;
    waitReady(modelLatency(10) + 100, lat, done);
    checkOutput("held_second_done", done, 1'b1);
    checkOutput("held_second_latency", lat, modelLatency(10));
    frames.delete();

    repeat (5) @(posedge raw_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
